spi_transmit: RTL and testbench

SPI_TRANSMIT -- requirements
Module: spi_transmit

---
 rtl/spi_transmit.sv | 146 ++++++++++++++
 tb/tb_spi_transmit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_transmit.sv
// spi_transmit: double-buffered SPI transmitter (target side).
// A word is loaded into a holding register, moved into a shift register when
// a transfer starts, and shifted out MSB first on sdo. Words can follow each
// other with no idle bit between them. If no word is waiting when a transfer
// starts, the module sends an all-zero word and flags an underrun.
module spi_transmit #(
   parameter int MESSAGE_BITS = 8
) (
   input  logic                    spiClk,
   input  logic                    nRst,
   input  logic                    cs,
   input  logic [MESSAGE_BITS-1:0] loadData,
   input  logic                    loadValid,
   output logic                    loadReady,
   output logic                    sdo,
   output logic                    txDone,
   output logic                    underrun,
   output logic                    aborted
);

   localparam int CW = $clog2(MESSAGE_BITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(MESSAGE_BITS - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                  state;
   state_t                  nextState;
   logic [MESSAGE_BITS-1:0] holdReg;
   logic                    holdFull;
   logic [MESSAGE_BITS-1:0] shiftReg;
   logic [CW-1:0]           cnt;

   // Decoded events for the current cycle
   logic startWord;
   logic shiftBit;
   logic wordDone;
   logic abortWord;
   logic stopWord;
   logic consume;
   logic starve;
   logic load;

   // State register; reset is synchronous to spiClk
   // NOTE: sequential state uses <= so every register sees pre-edge values.
   always_ff @(posedge spiClk) begin
      if (!nRst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: cs enters SHIFT from IDLE, dropping cs returns to IDLE
   always_comb begin
      // NOTE: default assignment first so no latch is inferred.
      nextState = state;
      case (state)
         IDLE:    if (cs)  nextState = SHIFT;
         SHIFT:   if (!cs) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Output and event decode from the current state and registers
   always_comb begin
      startWord = 1'b0;
      shiftBit  = 1'b0;
      wordDone  = 1'b0;
      abortWord = 1'b0;
      stopWord  = 1'b0;
      case (state)
         IDLE: begin
            startWord = cs;
         end
         SHIFT: begin
            if (cs) begin
               if (cnt == '0) begin
                  // Last bit done: finish this word and start the next one
                  wordDone  = 1'b1;
                  startWord = 1'b1;
               end else begin
                  shiftBit = 1'b1;
               end
            end else begin
               stopWord = 1'b1;
               // A word untouched since its start edge is not an abort
               abortWord = (cnt != CNT_LAST);
            end
         end
         default: ;
      endcase

      consume   = startWord && holdFull;
      starve    = startWord && !holdFull;
      // The flag gates loads directly: a word is accepted only into an empty
      // holding register, even if that register empties on this same edge.
      load      = loadValid && !holdFull;

      loadReady = !holdFull;
      sdo       = (state == SHIFT) ? shiftReg[MESSAGE_BITS-1] : 1'b0;
   end

   // Datapath: holding register, shift register, bit counter and event pulses
   always_ff @(posedge spiClk) begin
      if (!nRst) begin
         holdReg  <= '0;
         holdFull <= 1'b0;
         shiftReg <= '0;
         cnt      <= CNT_LAST;
         txDone   <= 1'b0;
         underrun <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         if (startWord) begin
            shiftReg <= holdFull ? holdReg : '0;
            cnt      <= CNT_LAST;
         end else if (shiftBit) begin
            shiftReg <= shiftReg << 1;
            cnt      <= cnt - 1'b1;
         end else if (stopWord) begin
            shiftReg <= '0;
            cnt      <= CNT_LAST;
         end

         // consume needs a full register and load an empty one, so at most
         // one of these fires on any edge
         if (consume) begin
            holdFull <= 1'b0;
         end else if (load) begin
            holdFull <= 1'b1;
         end

         if (load) begin
            holdReg <= loadData;
         end

         txDone   <= wordDone;
         underrun <= starve;
         aborted  <= abortWord;
      end
   end

endmodule

// File: tb/tb_spi_transmit.sv
// Directed bench for spi_transmit (MESSAGE_BITS = 8).
// Each vector gives the inputs for one rising edge and the outputs expected
// just after it, packed as {sdo, loadReady, txDone, underrun, aborted}.
module tb_spi_transmit;

   logic       spiClk;
   logic       nRst;
   logic       cs;
   logic [7:0] loadData;
   logic       loadValid;
   logic       loadReady;
   logic       sdo;
   logic       txDone;
   logic       underrun;
   logic       aborted;

   int total;
   int passed;

   typedef struct {
      logic       rstN;
      logic       csIn;
      logic       valid;
      logic [7:0] data;
      logic [4:0] expOut;
   } vec_t;

   vec_t vecs[$];

   spi_transmit #(.MESSAGE_BITS(8)) dut (
      .spiClk    (spiClk),
      .nRst      (nRst),
      .cs        (cs),
      .loadData  (loadData),
      .loadValid (loadValid),
      .loadReady (loadReady),
      .sdo       (sdo),
      .txDone    (txDone),
      .underrun  (underrun),
      .aborted   (aborted)
   );

   initial spiClk = 1'b0;
   always #5 spiClk = ~spiClk;

   function automatic vec_t mk(input logic r, input logic c, input logic v,
                               input logic [7:0] d, input logic [4:0] e);
      vec_t t;
      t.rstN   = r;
      t.csIn   = c;
      t.valid  = v;
      t.data   = d;
      t.expOut = e;
      return t;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one edge's inputs, clock it, and compare outputs on the falling edge
   task automatic run(input vec_t t, input string name);
      nRst      = t.rstN;
      cs        = t.csIn;
      loadValid = t.valid;
      loadData  = t.data;
      @(posedge spiClk);
      @(negedge spiClk);
      check(name, {sdo, loadReady, txDone, underrun, aborted}, t.expOut);
   endtask

   // Shorthand: cs high for n edges, no load, same expected output each edge
   function automatic void push_run(input int n, input logic [4:0] e);
      for (int i = 0; i < n; i++) vecs.push_back(mk(1, 1, 0, 8'h00, e));
   endfunction

   initial begin
      int tdCount;
      int urCount;
      logic prevTd;
      logic prevUr;

      total     = 0;
      passed    = 0;
      nRst      = 1'b0;
      cs        = 1'b0;
      loadValid = 1'b0;
      loadData  = 8'h00;

      // Reset, including reset with cs and loadValid active
      vecs.push_back(mk(0, 0, 0, 8'h00, 5'b01000));
      vecs.push_back(mk(0, 1, 1, 8'hEE, 5'b01000));
      vecs.push_back(mk(1, 0, 0, 8'h00, 5'b01000));

      // Single word 0xA5: 1,0,1,0,0,1,0,1 then txDone (next start underruns)
      vecs.push_back(mk(1, 0, 1, 8'hA5, 5'b00000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b11000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b11000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b11000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b11000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01110));
      vecs.push_back(mk(1, 0, 0, 8'h00, 5'b01000));

      // Back-to-back 0x3C then 0xC3 (0xC3 loaded during the first word)
      vecs.push_back(mk(1, 0, 1, 8'h3C, 5'b00000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01000));
      vecs.push_back(mk(1, 1, 1, 8'hC3, 5'b00000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b10000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b10000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b10000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b10000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b00000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b00000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b11100));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b11000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b11000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b11000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01110));
      vecs.push_back(mk(1, 0, 0, 8'h00, 5'b01000));

      // No load: zero word, underrun at start, txDone at end
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01010));
      push_run(7, 5'b01000);
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01110));
      vecs.push_back(mk(1, 0, 0, 8'h00, 5'b01000));

      // Abort after 3 bits of 0xFF; the consumed word is gone, next underruns
      vecs.push_back(mk(1, 0, 1, 8'hFF, 5'b00000));
      push_run(3, 5'b11000);
      vecs.push_back(mk(1, 0, 0, 8'h00, 5'b01001));
      vecs.push_back(mk(1, 0, 0, 8'h00, 5'b01000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01010));
      vecs.push_back(mk(1, 0, 0, 8'h00, 5'b01000));

      // Load while full is ignored: 0x81 dropped, 0x42 = 0,1,0,0,0,0,1,0 sent
      vecs.push_back(mk(1, 0, 1, 8'h42, 5'b00000));
      vecs.push_back(mk(1, 0, 1, 8'h81, 5'b00000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b11000));
      push_run(4, 5'b01000);
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b11000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01000));
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b01110));
      vecs.push_back(mk(1, 0, 0, 8'h00, 5'b01000));

      // Load on an empty-start edge: zero word now, 0x96 (MSB 1) next word
      vecs.push_back(mk(1, 1, 1, 8'h96, 5'b00010));
      push_run(7, 5'b00000);
      vecs.push_back(mk(1, 1, 0, 8'h00, 5'b11100));
      vecs.push_back(mk(1, 0, 0, 8'h00, 5'b01000));

      foreach (vecs[i]) begin
         run(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset at bit 4 of 0x5A: nothing pulses, both registers discarded
      run(mk(1, 0, 1, 8'h5A, 5'b00000), "rst_load");
      run(mk(1, 1, 0, 8'h00, 5'b01000), "rst_b7");
      run(mk(1, 1, 0, 8'h00, 5'b11000), "rst_b6");
      run(mk(1, 1, 0, 8'h00, 5'b01000), "rst_b5");
      run(mk(1, 1, 0, 8'h00, 5'b11000), "rst_b4");
      run(mk(0, 1, 0, 8'h00, 5'b01000), "rst_mid");
      run(mk(1, 0, 0, 8'h00, 5'b01000), "rst_after");
      run(mk(1, 1, 0, 8'h00, 5'b01010), "rst_underrun");
      run(mk(1, 0, 0, 8'h00, 5'b01000), "rst_idle");

      // 40 edges of continuous cs with nothing loaded: five zero words
      // started, four completed, every pulse exactly one cycle wide
      tdCount   = 0;
      urCount   = 0;
      prevTd    = 1'b0;
      prevUr    = 1'b0;
      cs        = 1'b1;
      loadValid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge spiClk);
         @(negedge spiClk);
         if (txDone && prevTd) check("td_width", 2, 1);
         if (underrun && prevUr) check("ur_width", 2, 1);
         if (txDone)   tdCount++;
         if (underrun) urCount++;
         prevTd = txDone;
         prevUr = underrun;
      end
      check("long_txdone", tdCount, 4);
      check("long_underrun", urCount, 5);

      // Dropping cs while the last bit is on the wire is an abort, not a done
      run(mk(1, 0, 0, 8'h00, 5'b01001), "abort_lastbit");
      run(mk(1, 0, 0, 8'h00, 5'b01000), "abort_clear");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
